// File: rtl/wave_trigger_capture.sv
// Captures one frame of audio into the hidden half of the ping-pong wave RAM,
// starting on a positive zero crossing and flipping the displayed half during vsync.
module wave_trigger_capture #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W:0]     write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    ARMED,
    ACTIVE,
    WAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              prev_valid;
  logic              prev_neg;
  logic [7:0]        s8;
  logic [7:0]        converted;
  logic              trigger;

  // Top byte flipped so positive full-scale lands at the top of the screen (127 - s8).
  assign s8        = new_sample_in[SAMPLE_W-1 -: 8];
  assign converted = {s8[7], ~s8[6:0]};
  assign trigger   = new_sample_ready & prev_valid & prev_neg & ~new_sample_in[SAMPLE_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARMED;
      count         <= '0;
      prev_valid    <= 1'b0;
      prev_neg      <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) begin
        prev_valid <= 1'b1;
        prev_neg   <= new_sample_in[SAMPLE_W-1];
      end
      case (state)
        ARMED: begin
          if (trigger) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {ADDR_W{1'b0}}};
            write_sample  <= converted;
            count         <= {{(ADDR_W-1){1'b0}}, 1'b1};
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= converted;
            count         <= count + 1'b1;
            if (&count) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // The flip is the only place read_index moves, so the shown half is never written.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_trigger_capture.sv
// Randomized bench for wave_trigger_capture, checked every cycle against a frame-level
// model (samples written per frame, waiting flag, displayed half) kept in the bench.
module tb_wave_trigger_capture;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic                clk;
  logic                reset;
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model state
  int m_captured;
  bit m_waiting;
  bit m_ri;
  bit m_prev_valid;
  int m_prev;
  bit exp_we;
  int exp_addr;
  int exp_data;

  wave_trigger_capture #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_captured   = 0;
    m_waiting    = 1'b0;
    m_ri         = 1'b0;
    m_prev_valid = 1'b0;
    m_prev       = 0;
    exp_we       = 1'b0;
    exp_addr     = 0;
    exp_data     = 0;
  endtask

  task automatic model_write(input int idx, input int s);
    exp_we   = 1'b1;
    exp_addr = (m_ri ? 0 : DEPTH) + idx;
    exp_data = (127 - (s >>> (SAMPLE_W - 8))) & 8'hFF;
  endtask

  // One clock of the model, using the inputs present at the rising edge
  task automatic model_step(input bit nsr, input logic [SAMPLE_W-1:0] raw, input bit idle);
    int s;
    s      = int'($signed(raw));
    exp_we = 1'b0;
    if (m_waiting) begin
      if (idle) begin
        m_ri       = ~m_ri;
        m_waiting  = 1'b0;
        m_captured = 0;
      end
    end else if (m_captured == 0) begin
      if (nsr && m_prev_valid && m_prev < 0 && s >= 0) begin
        model_write(0, s);
        m_captured = 1;
      end
    end else if (nsr) begin
      model_write(m_captured, s);
      m_captured++;
      if (m_captured == DEPTH) m_waiting = 1'b1;
    end
    if (nsr) begin
      m_prev       = s;
      m_prev_valid = 1'b1;
    end
  endtask

  task automatic check_output();
    check("write_enable", int'(write_enable), int'(exp_we));
    check("read_index", int'(read_index), int'(m_ri));
    if (exp_we) begin
      check("write_address", int'(write_address), exp_addr);
      check("write_sample", int'(write_sample), exp_data);
    end
  endtask

  task automatic apply_stimulus(input bit nsr, input logic [SAMPLE_W-1:0] s, input bit idle);
    new_sample_ready  = nsr;
    new_sample_in     = s;
    wave_display_idle = idle;
    @(posedge clk);
    model_step(nsr, s, idle);
    @(negedge clk);
    check_output();
  endtask

  function automatic logic [SAMPLE_W-1:0] rand_sample();
    logic [SAMPLE_W-1:0] v;
    case ($urandom_range(3))
      0:       v = 16'(-int'($urandom_range(2000)));
      1:       v = 16'($urandom_range(2000));
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Feed samples until the model reports a full frame; budget overrun counts as a failure
  task automatic fill_frame(input int budget, input bit back_to_back, input bit idle);
    int i;
    i = 0;
    while (!m_waiting && i < budget) begin
      apply_stimulus(back_to_back ? 1'b1 : 1'($urandom_range(1)), rand_sample(), idle);
      i++;
    end
    check("frame_complete", int'(m_waiting), 1);
  endtask

  initial begin
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_we", int'(write_enable), 0);
    check("reset_addr", int'(write_address), 0);
    check("reset_sample", int'(write_sample), 0);
    check("reset_ri", int'(read_index), 0);
    reset = 1'b0;

    // First sample after reset can never trigger
    apply_stimulus(1'b1, 16'h0100, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b0);
    apply_stimulus(1'b1, 16'hFFFF, 1'b0);
    apply_stimulus(1'b1, 16'h0000, 1'b0);
    check("trig_addr_lit", int'(write_address), 'h100);
    check("trig_sample_lit", int'(write_sample), 'h7F);
    apply_stimulus(1'b1, 16'h0500, 1'b0);
    check("second_addr_lit", int'(write_address), 'h101);
    apply_stimulus(1'b1, 16'h0A00, 1'b0);

    fill_frame(3000, 1'b0, 1'b0);
    check("last_addr_lit", int'(write_address), 'h1FF);
    for (int i = 0; i < 1000; i++) apply_stimulus(1'($urandom_range(1)), rand_sample(), 1'b0);
    check("ri_hold_lit", int'(read_index), 0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check("ri_flip_lit", int'(read_index), 1);

    // Back-to-back frame into half 0 with full-scale conversion checks
    apply_stimulus(1'b1, 16'h8000, 1'b0);
    apply_stimulus(1'b1, 16'h7FFF, 1'b0);
    check("pos_max_addr_lit", int'(write_address), 'h000);
    check("pos_max_sample_lit", int'(write_sample), 'h00);
    apply_stimulus(1'b1, 16'h8000, 1'b0);
    check("neg_max_addr_lit", int'(write_address), 'h001);
    check("neg_max_sample_lit", int'(write_sample), 'hFF);
    fill_frame(600, 1'b1, 1'b1);
    apply_stimulus(1'b1, rand_sample(), 1'b1);
    check("ri_early_idle_lit", int'(read_index), 0);

    // Abandon a frame at count=100
    apply_stimulus(1'b1, 16'hFF00, 1'b0);
    apply_stimulus(1'b1, 16'h0100, 1'b0);
    while (m_captured < 100 && !m_waiting) apply_stimulus(1'b1, rand_sample(), 1'b0);
    check("captured_100", m_captured, 100);
    #2 reset = 1'b1;
    new_sample_ready = 1'b0;
    #1;
    model_reset();
    check("midreset_we_lit", int'(write_enable), 0);
    check("midreset_ri_lit", int'(read_index), 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, 16'hFFFB, 1'b0);
    apply_stimulus(1'b1, 16'h0005, 1'b0);
    check("restart_we_lit", int'(write_enable), 1);
    check("restart_addr_lit", int'(write_address), 'h100);
    fill_frame(3000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
